// File: rtl/perf_counter_bank_if.sv
// Bus bundle for perf_counter_bank: PC trace, event qualifiers, clear,
// readout request/response and status flags. The master side is the
// CPU/debug logic that drives the block; the slave side is the counter bank.
interface perf_counter_bank_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int COUNT_WIDTH  = 32,
  parameter int IDX_W        = 2
);
  logic [15:0]              pc;
  logic [NUM_CHANNELS-1:0]  event_in;
  logic                     clear;
  logic                     rd_req;
  logic [IDX_W-1:0]         rd_idx;
  logic                     rd_valid;
  logic [COUNT_WIDTH-1:0]   rd_data;
  logic [NUM_CHANNELS-1:0]  ovf;
  logic                     running;
  logic                     done;

  modport master (
    output pc, event_in, clear, rd_req, rd_idx,
    input  rd_valid, rd_data, ovf, running, done
  );

  modport slave (
    input  pc, event_in, clear, rd_req, rd_idx,
    output rd_valid, rd_data, ovf, running, done
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of PC-windowed event counters. Counting is armed when the PC hits
// START_PC and stops after the cycle in which the PC hits FINAL_PC; the
// bank then sits in DONE until cleared. Each counter carries a sticky
// overflow flag, and any channel can be read back one cycle after a request.
// Build option: define PERF_SATURATE_EN to make counters stick at all-ones
// instead of wrapping to zero; overflow flags behave the same either way.
module perf_counter_bank #(
  parameter int          NUM_CHANNELS = 4,
  parameter int          COUNT_WIDTH  = 32,
  parameter logic [15:0] START_PC     = 16'h0000,
  parameter logic [15:0] FINAL_PC     = 16'hFFFF,
  parameter int          IDX_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                 cpu_clk,
  input  logic                 resetN,
  perf_counter_bank_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic [COUNT_WIDTH-1:0]   r_count [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  r_ovf;
  logic                     r_rdValid;
  logic [COUNT_WIDTH-1:0]   r_rdData;
  logic [COUNT_WIDTH-1:0]   w_rdSel;

  // State register; reset and clear both park the FSM in IDLE.
  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_nextState;
  end

  // Next-state: clear wins over PC matches, and DONE ignores the PC entirely.
  always_comb begin
    w_nextState = r_state;
    if (bus.clear) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.pc == START_PC)
            w_nextState = (START_PC == FINAL_PC) ? DONE : COUNTING;
        end
        COUNTING: begin
          if (bus.pc == FINAL_PC) w_nextState = DONE;
        end
        DONE:    w_nextState = DONE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Counters advance off the registered state, so the arming cycle is not
  // counted but the FINAL_PC cycle is; an event at all-ones flags overflow.
  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_CHANNELS; i++) r_count[i] <= '0;
      r_ovf <= '0;
    end else if (bus.clear) begin
      for (int i = 0; i < NUM_CHANNELS; i++) r_count[i] <= '0;
      r_ovf <= '0;
    end else if (r_state == COUNTING) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (bus.event_in[i]) begin
          if (&r_count[i]) begin
            r_ovf[i] <= 1'b1;
`ifdef PERF_SATURATE_EN
            r_count[i] <= r_count[i];
`else
            r_count[i] <= '0;
`endif
          end else begin
            r_count[i] <= r_count[i] + COUNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Readout mux; indices past the last channel select zero.
  always_comb begin
    w_rdSel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (bus.rd_idx == IDX_W'(i)) w_rdSel = r_count[i];
    end
  end

  // Readout register captures the pre-increment value and holds it between requests.
  always_ff @(posedge cpu_clk or negedge resetN) begin
    if (!resetN) begin
      r_rdValid <= 1'b0;
      r_rdData  <= '0;
    end else begin
      r_rdValid <= bus.rd_req;
      if (bus.rd_req) r_rdData <= w_rdSel;
    end
  end

  assign bus.rd_valid = r_rdValid;
  assign bus.rd_data  = r_rdData;
  assign bus.ovf      = r_ovf;
  assign bus.running  = (r_state == COUNTING);
  assign bus.done     = (r_state == DONE);

endmodule
